// File: rtl/cnn_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Types and default dimensions shared by the CNN weight-loading
//               path and the feature weight memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

    // Default kernel geometry and weight precision
    localparam int DEF_KERNEL_SIZE  = 4;
    localparam int DEF_NUM_FEATURES = 3;
    localparam int DEF_DATA_WIDTH   = 8;

    // Feature memory address width; bounds the number of kernels at 4
    localparam int ADDR_W = 2;

    // Weight loader sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/feature_weight_loader.sv
// ============================================================================
// Module      : feature_weight_loader
// Description : Collects a serial stream of signed weights into flattened
//               KERNEL_SIZE x KERNEL_SIZE kernels and writes each one into the
//               feature weight memory (active-low write enable) at addresses
//               0..NUM_FEATURES-1, then pulses done.
//               Element i of a kernel (row-major) sits in bits
//               [i*DATA_WIDTH +: DATA_WIDTH] of feature_weights_input.
//               Optional macro FEATURE_LOADER_CHECKSUM_EN adds a signed
//               running sum of all accepted weights on port checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module feature_weight_loader
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int NUM_FEATURES = DEF_NUM_FEATURES,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               start,
    input  logic                                               wt_valid,
    input  logic signed [DATA_WIDTH-1:0]                       wt_data,
    output logic                                               wt_ready,
    output logic [ADDR_W-1:0]                                  address_w,
    output logic                                               feature_WrEn,
    output logic signed [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] feature_weights_input,
    output logic                                               busy,
    output logic                                               done
`ifdef FEATURE_LOADER_CHECKSUM_EN
   ,output logic signed [DATA_WIDTH+7:0]                       checksum
`endif
);

    localparam int NW    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int KW    = NW * DATA_WIDTH;

    // The write address is only ADDR_W bits wide
    if (NUM_FEATURES < 1 || NUM_FEATURES > (1 << ADDR_W)) begin : g_bad_num_features
        $error("feature_weight_loader: NUM_FEATURES must be in 1..4");
    end

    loader_state_t          state_q, state_d;
    logic [IDX_W-1:0]       idx_q,   idx_d;
    logic [ADDR_W-1:0]      addr_q,  addr_d;
    logic [KW-1:0]          buf_q,   buf_d;
    logic                   wren_q,  wren_d;
    logic                   done_q,  done_d;

    // Next-state logic; write enable and done are computed from the next state
    // so they come straight out of flops and cannot glitch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    idx_d   = '0;
                    addr_d  = '0;
                end
            end
            COLLECT: begin
                if (wt_valid) begin
                    buf_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = wt_data;
                    if (idx_q == IDX_W'(NW - 1)) begin
                        idx_d   = '0;
                        state_d = WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                // Address advances only after the write cycle has ended
                if (addr_q == ADDR_W'(NUM_FEATURES - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = COLLECT;
                    addr_d  = addr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wren_d = (state_d != WRITE);
        done_d = (state_d == DONE);
    end

    // State, buffer and registered memory-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            wren_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
        end
    end

`ifdef FEATURE_LOADER_CHECKSUM_EN
    logic signed [DATA_WIDTH+7:0] sum_q, sum_d;

    // Running sum of accepted weights, restarted by a new load
    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && start) begin
            sum_d = '0;
        end else if (state_q == COLLECT && wt_valid) begin
            sum_d = sum_q + {{8{wt_data[DATA_WIDTH-1]}}, wt_data};
        end
    end

    // Checksum accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

    assign wt_ready              = (state_q == COLLECT);
    assign busy                  = (state_q != IDLE);
    assign address_w             = addr_q;
    assign feature_WrEn          = wren_q;
    assign done                  = done_q;
    assign feature_weights_input = buf_q;

endmodule

`default_nettype wire

// File: tb/tb_feature_weight_loader.sv
// ============================================================================
// Module      : tb_feature_weight_loader
// Description : Scoreboard bench for feature_weight_loader (default geometry)
//               plus a small 2x2 / single-kernel instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_feature_weight_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, start, wt_valid;
    logic signed [7:0]  wt_data;
    logic               wt_ready, feature_WrEn, busy, done;
    logic [1:0]         address_w;
    logic [127:0]       feature_weights_input;
`ifdef FEATURE_LOADER_CHECKSUM_EN
    logic signed [15:0] checksum;
    logic signed [15:0] s_checksum;
`endif

    logic               s_start, s_valid, s_ready, s_wren, s_busy, s_done;
    logic signed [7:0]  s_data;
    logic [1:0]         s_addr;
    logic [31:0]        s_kernel;

    feature_weight_loader dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .wt_valid              (wt_valid),
        .wt_data               (wt_data),
        .wt_ready              (wt_ready),
        .address_w             (address_w),
        .feature_WrEn          (feature_WrEn),
        .feature_weights_input (feature_weights_input),
        .busy                  (busy),
        .done                  (done)
`ifdef FEATURE_LOADER_CHECKSUM_EN
       ,.checksum              (checksum)
`endif
    );

    feature_weight_loader #(.KERNEL_SIZE(2), .NUM_FEATURES(1), .DATA_WIDTH(8)) dut_small (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (s_start),
        .wt_valid              (s_valid),
        .wt_data               (s_data),
        .wt_ready              (s_ready),
        .address_w             (s_addr),
        .feature_WrEn          (s_wren),
        .feature_weights_input (s_kernel),
        .busy                  (s_busy),
        .done                  (s_done)
`ifdef FEATURE_LOADER_CHECKSUM_EN
       ,.checksum              (s_checksum)
`endif
    );

    typedef struct {
        bit                 is_done;
        logic [1:0]         addr;
        logic [127:0]       data;
        logic signed [15:0] sum;
    } ev_t;

    ev_t                exp_q[$];
    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 cyc      = 0;
    int                 hs_cnt   = 0;
    int                 done_cnt = 0;
    int                 done_cyc = 0;
    int                 start_cyc = 0;
    bit                 prev_wr  = 1'b0;
    logic [127:0]       mem     [4];
    logic [127:0]       exp_mem [4];

    // model state for the kernel currently being streamed
    logic [127:0]       kacc;
    int                 kidx, kaddr;
    logic signed [15:0] ksum;

    // small instance observation
    int                 s_wr_cnt = 0;
    int                 s_wr_cyc = -100;
    int                 s_done_cyc = -100;
    logic [1:0]         s_wr_addr;
    logic [31:0]        s_wr_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Monitor: pops expected writes/done and models the feature memory
    always @(negedge clk) begin
        if (rst) begin
            if (wt_valid && wt_ready) hs_cnt++;
            if (!feature_WrEn) begin
                mem[address_w] = feature_weights_input;
                chk("ready_low_in_write", {127'd0, wt_ready}, 128'd0);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("write_kind", {127'd0, e.is_done}, 128'd0);
                    chk("write_addr", {126'd0, address_w}, {126'd0, e.addr});
                    chk("write_kernel", feature_weights_input, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_write", {127'd0, prev_wr}, 128'd1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("done_kind", {127'd0, e.is_done}, 128'd1);
`ifdef FEATURE_LOADER_CHECKSUM_EN
                    chk("checksum_at_done", {{112{checksum[15]}}, checksum}, {{112{e.sum[15]}}, e.sum});
`endif
                end
            end
            prev_wr = !feature_WrEn;
        end else begin
            prev_wr = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (!s_wren) begin
                s_wr_cnt++;
                s_wr_addr = s_addr;
                s_wr_data = s_kernel;
                s_wr_cyc  = cyc;
            end
            if (s_done) s_done_cyc = cyc;
        end
    end

    task automatic model_clear();
        kacc  = '0;
        kidx  = 0;
        kaddr = 0;
        ksum  = '0;
        exp_q.delete();
    endtask

    task automatic begin_load();
        model_clear();
        hs_cnt    = 0;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Present one weight after 'gap' idle cycles; returns #1 after it is taken
    task automatic send_weight(input logic signed [7:0] v, input int gap);
        bit taken;
        taken = 1'b0;
        wt_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        wt_valid = 1'b1;
        wt_data  = v;
        for (int t = 0; t < 50 && !taken; t++) begin
            bit r;
            @(negedge clk);
            r = wt_ready;
            @(posedge clk); #1;
            taken = r;
        end
        wt_valid = 1'b0;
        if (!taken) fail_now("weight_accept");
        else begin
            ev_t e;
            kacc[kidx*8 +: 8] = v;
            ksum = ksum + v;
            kidx++;
            if (kidx == 16) begin
                e = '{is_done: 1'b0, addr: 2'(kaddr), data: kacc, sum: ksum};
                exp_q.push_back(e);
                exp_mem[kaddr] = kacc;
                kidx = 0;
                kaddr++;
                if (kaddr == 3) begin
                    e = '{is_done: 1'b1, addr: 2'd0, data: '0, sum: ksum};
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_done(input int base);
        for (int t = 0; t < 200 && done_cnt == base; t++) begin
            @(posedge clk); #1;
        end
        if (done_cnt == base) fail_now("done_wait");
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 3; a++) chk({tag, "_mem"}, mem[a], exp_mem[a]);
    endtask

    initial begin
        int base;
        rst = 1'b0; start = 1'b0; wt_valid = 1'b0; wt_data = '0;
        s_start = 1'b0; s_valid = 1'b0; s_data = '0;
        for (int a = 0; a < 4; a++) begin mem[a] = '0; exp_mem[a] = '0; end
        model_clear();
        repeat (3) @(posedge clk); #1;

        chk("rst_ready", {127'd0, wt_ready}, 128'd0);
        chk("rst_wren",  {127'd0, feature_WrEn}, 128'd1);
        chk("rst_busy",  {127'd0, busy}, 128'd0);
        chk("rst_done",  {127'd0, done}, 128'd0);
        chk("rst_addr",  {126'd0, address_w}, 128'd0);
        chk("rst_buf",   feature_weights_input, 128'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // continuous stream 0..47
        base = done_cnt;
        begin_load();
        chk("busy_collect", {127'd0, busy}, 128'd1);
        for (int i = 0; i < 48; i++) send_weight(8'(i), 0);
        wait_done(base);
        chk("done_latency", 128'(done_cyc - start_cyc), 128'd52);
        chk("hs_count_seq", 128'(hs_cnt), 128'd48);
        chk("mem_row1", mem[1], {8'd31,8'd30,8'd29,8'd28,8'd27,8'd26,8'd25,8'd24,
                                 8'd23,8'd22,8'd21,8'd20,8'd19,8'd18,8'd17,8'd16});
        check_mem("seq");

        // random values with valid gaps
        base = done_cnt;
        begin_load();
        for (int i = 0; i < 48; i++) send_weight(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
        wait_done(base);
        chk("hs_count_gaps", 128'(hs_cnt), 128'd48);
        check_mem("gaps");

        // start re-pulsed mid-collect is ignored
        base = done_cnt;
        begin_load();
        for (int i = 0; i < 5; i++) send_weight(8'(-i), 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 5; i < 48; i++) send_weight(8'(-i), 0);
        wait_done(base);
        chk("hs_count_restart", 128'(hs_cnt), 128'd48);
        chk("done_count_restart", 128'(done_cnt - base), 128'd1);
        check_mem("restart");

        // reset mid-operation, then a clean reload
        begin_load();
        for (int i = 0; i < 20; i++) send_weight(8'(3*i - 60), 0);
        rst = 1'b0;
        #1;
        chk("abort_wren",  {127'd0, feature_WrEn}, 128'd1);
        chk("abort_busy",  {127'd0, busy}, 128'd0);
        chk("abort_ready", {127'd0, wt_ready}, 128'd0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        base = done_cnt;
        begin_load();
        for (int i = 0; i < 48; i++) send_weight(8'(100 - 5*i), 0);
        wait_done(base);
        check_mem("reload");

        // 2x2 kernel, single feature
        s_start = 1'b1;
        begin
            int s0;
            s0 = cyc;
            @(posedge clk); #1;
            s_start = 1'b0;
            s_valid = 1'b1;
            s_data = -8'sd1; @(posedge clk); #1;
            s_data =  8'sd2; @(posedge clk); #1;
            s_data = -8'sd3; @(posedge clk); #1;
            s_data =  8'sd4; @(posedge clk); #1;
            s_valid = 1'b0;
            repeat (5) @(posedge clk); #1;
            chk("small_wr_count", 128'(s_wr_cnt), 128'd1);
            chk("small_wr_addr",  {126'd0, s_wr_addr}, 128'd0);
            chk("small_kernel",   {96'd0, s_wr_data}, {96'd0, 32'h04FD_02FF});
            chk("small_done_lat", 128'(s_done_cyc - s0), 128'd6);
        end

`ifdef FEATURE_LOADER_CHECKSUM_EN
        base = done_cnt;
        begin_load();
        for (int i = 0; i < 48; i++) send_weight(8'sd127, 0);
        wait_done(base);
        repeat (3) @(posedge clk); #1;
        chk("checksum_127_held", {{112{checksum[15]}}, checksum}, 128'd6096);
`endif

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/feature_weight_loader.md
Name: feature_weight_loader

Overview:
Sequences loading of convolution kernel weights into the feature weight memory before inference.
- Accepts a serial stream of signed weights on a valid/ready handshake.
- Assembles each group of KERNEL_SIZE*KERNEL_SIZE weights into a flattened kernel.
- Issues one active-low write per feature at addresses 0..NUM_FEATURES-1, then signals completion.
- Sits between the external configuration interface and the feature weight memory; drives that memory's address_w, feature_WrEn and feature_weights_input directly.

Parameters:
- KERNEL_SIZE, 4, kernel side length; one kernel holds KERNEL_SIZE*KERNEL_SIZE weights.
- NUM_FEATURES, 3, number of kernels to load. Range 1..4 because address_w is 2 bits; elaboration-time assertion.
- DATA_WIDTH, 8, signed weight width.

Ports:
- clk  in  1  main chip clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load sequence; ignored unless in IDLE.
- wt_valid  in  1  stream weight valid.
- wt_data  in  DATA_WIDTH signed  stream weight; row-major order within a kernel, kernel 0 first.
- wt_ready  out  1  loader can accept wt_data.
- address_w  out  2  feature memory write address.
- feature_WrEn  out  1  active-low write enable to feature memory.
- feature_weights_input  out  DATA_WIDTH signed x KERNEL_SIZE*KERNEL_SIZE  assembled kernel.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the last kernel has been written.

Behaviour:
- Reset values: state=IDLE, wt_ready=0, feature_WrEn=1, address_w=0, kernel buffer all 0, weight index=0, done=0, busy=0.
- States:
  - IDLE: start=1 goes to COLLECT; weight index and address_w cleared.
  - COLLECT: wt_ready=1. A handshake occurs when wt_valid&&wt_ready; it writes wt_data into buffer[index] and increments index. The handshake at index KERNEL_SIZE*KERNEL_SIZE-1 goes to WRITE and resets index to 0.
  - WRITE: wt_ready=0, feature_WrEn=0 for exactly one clk cycle. address_w and buffer are held stable the whole cycle, so the memory's negedge capture sees stable data. If address_w==NUM_FEATURES-1, go to DONE; else go to COLLECT with address_w+1.
  - DONE: done=1 for one cycle, feature_WrEn=1, then go to IDLE.
- Latency: feature_WrEn is low in the cycle immediately after the final handshake of a kernel. done is high in the cycle after the last WRITE.
- Minimum full load time: NUM_FEATURES*(KERNEL_SIZE^2+1)+2 cycles from start with continuous wt_valid.
- wt_valid gaps stall COLLECT indefinitely; there is no timeout.
- wt_data presented while wt_ready=0 is not consumed.
- start while busy is ignored. start and wt_valid in the same IDLE cycle: that weight is not consumed (wt_ready=0 in IDLE).
- Reset mid-operation aborts the sequence. All outputs return to reset values immediately; feature_WrEn deasserts asynchronously. Partially written memory content is left as is.
- feature_WrEn is glitch-free: a registered output only.
- Buffer is not cleared between kernels; every element is overwritten before each WRITE.

Optional Feature:
FEATURE_LOADER_CHECKSUM_EN
- Defined:
  - Adds output checksum, width DATA_WIDTH+8, signed.
  - Running two's-complement sum of all accepted weights, cleared on start and on reset.
  - Valid and held from the done pulse until the next start.
- Undefined: no port and no accumulator logic.

Decomposition:
- Shared package cnn_pkg:
  - FSM enum loader_state_t {IDLE, COLLECT, WRITE, DONE}.
  - Default KERNEL_SIZE/NUM_FEATURES/DATA_WIDTH localparams.
  - ADDR_W=2 constant shared with the feature memory.
- No sub-module needed; the kernel buffer and FSM live in one module.

Test Plan:
- Reset then start, stream weights 0..47 continuously (defaults):
  - three feature_WrEn low pulses with address_w=0,1,2.
  - buffer at the 2nd pulse = 16..31.
  - done one cycle after the 3rd pulse.
  - a bench-modeled feature memory holds rows 0..15/16..31/32..47.
- Random wt_valid gaps (50% duty), values -128..127: memory contents match the sent order; wt_ready=0 in each WRITE cycle; no weight lost or duplicated.
- start pulsed again during COLLECT after 5 weights: ignored; sequence completes normally with exactly 48 handshakes.
- rst asserted after 20 weights: feature_WrEn=1, busy=0, wt_ready=0 immediately. A fresh start plus 48 weights reloads all three kernels correctly.
- NUM_FEATURES=1, KERNEL_SIZE=2, weights {-1,2,-3,4}: single write at address 0 with buffer {-1,2,-3,4}, done 6 cycles after start.
- With FEATURE_LOADER_CHECKSUM_EN, weights all 127 x48: checksum=6096 at done.
